mdu_sequencer: RTL
==================

// Module: mdu_sequencer
//
// PURPOSE
//   Iterative multiply/divide unit for the RV32M extension, with its own sequencer.
//   Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU decoded by the datapath
//   controller. Radix-2 shift-add multiply and restoring divide, one bit per cycle.
//   The pipeline stalls on o_busy until the o_done pulse, then takes o_result as
//   the register write-back value.
//
// PARAMETERS
//   DATA_WIDTH  32  operand/result width; iteration count = DATA_WIDTH
//
// PORTS
//   i_clock    in   1           clock, all state on rising edge
//   i_reset    in   1           asynchronous, active-high reset
//   i_start    in   1           request; accepted only when o_ready=1
//   i_op       in   3           funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,
//                               100 DIV,101 DIVU,110 REM,111 REMU
//   i_dataA    in   DATA_WIDTH  rs1 (multiplicand / dividend)
//   i_dataB    in   DATA_WIDTH  rs2 (multiplier / divisor)
//   i_flush    in   1           abort current operation (pipeline flush)
//   o_ready    out  1           state==IDLE
//   o_busy     out  1           operation accepted and not yet done (stall request)
//   o_done     out  1           one-cycle pulse, o_result valid this cycle
//   o_result   out  DATA_WIDTH  result; holds last value until next o_done
//
// BEHAVIOUR
//   Reset (async): state=IDLE, o_ready=1, o_busy=0, o_done=0, o_result=0, counter=0.
//   i_op, i_dataA and i_dataB are registered on acceptance and may change afterwards.
//   FSM states:
//   - IDLE -> PREP on i_start.
//   - PREP (1 cycle): compute absolute values.
//     * MULH and DIV/REM: both operands signed.
//     * MULHSU: A signed, B unsigned.
//     * Record the result-sign flag.
//     * Detect the divide special cases; if one is found, go to FINISH, else CALC.
//   - CALC (DATA_WIDTH cycles): counter counts 0..DATA_WIDTH-1.
//     * Multiply: 2*DATA_WIDTH-bit product register.
//     * Divide: remainder/quotient shift register.
//     * On counter==DATA_WIDTH-1 go to FINISH.
//   - FINISH (1 cycle): apply sign correction, load o_result, o_done=1, then IDLE.
//   Latency (accepting edge to o_done high):
//   - Normal: DATA_WIDTH+2 cycles (34 at default).
//   - Special cases: 2 cycles.
//   o_busy = (state != IDLE), so it is still high in FINISH.
//   Next start is accepted the cycle after o_done, so back-to-back issue is allowed.
//   Result selection:
//   - MUL: low half of the product.
//   - MULH/MULHSU/MULHU: high half of the two's-complement signed/unsigned product.
//   - DIV/DIVU: quotient truncated toward zero.
//   - REM/REMU: remainder takes the sign of the dividend.
//   Special cases (RISC-V spec):
//   - Divide by zero: quotient = all ones; remainder = dividend (unmodified A).
//   - Signed overflow (A = most negative, B = -1): quotient = A; remainder = 0.
//   Boundary conditions:
//   - i_start while not IDLE is ignored; no queueing.
//   - i_flush has priority over everything: next edge forces IDLE, suppresses o_done,
//     leaves o_result unchanged. An i_start in the same cycle as i_flush is ignored.
//   - Reset mid-operation: immediate IDLE, outputs at reset values.
//   - Counter wraps to 0 on leaving CALC; no state carries over between operations.
//
// TESTING
//   MUL 7 x 0xFFFFFFFD -> o_result=0xFFFFFFEB, o_done exactly 34 cycles after start
//   MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE;
//     MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF
//   DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14
//   DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, each with o_done 2 cycles after start;
//     DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0
//   i_flush at CALC cycle 10 -> IDLE next edge, no o_done, o_result keeps prior value;
//     i_start during busy ignored; restart completes normally
//   Assert i_reset asynchronously mid-CALC -> o_busy=0, o_ready=1, o_result=0 before
//     the next clock edge

Source files
------------

// File: rtl/mdu_sequencer_if.sv
// Request/response bundle between the pipeline
// controller and the iterative multiply/divide unit.
interface mdu_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_start;
  logic [2:0]            i_op;
  logic [DATA_WIDTH-1:0] i_dataA;
  logic [DATA_WIDTH-1:0] i_dataB;
  logic                  i_flush;
  logic                  o_ready;
  logic                  o_busy;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_result;

  modport master (
    output i_start, i_op, i_dataA,
    output i_dataB, i_flush,
    input  o_ready, o_busy,
    input  o_done, o_result
  );

  modport slave (
    input  i_start, i_op, i_dataA,
    input  i_dataB, i_flush,
    output o_ready, o_busy,
    output o_done, o_result
  );
endinterface

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide: radix-2 shift-add multiply and
// restoring divide on magnitudes, one bit per cycle.
module mdu_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input logic           i_clock,
  input logic           i_reset,
  mdu_sequencer_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    FINISH
  } state_t;

  state_t state;
  state_t stateNext;

  logic [2:0]    opReg;
  logic [W-1:0]  aReg;
  logic [W-1:0]  bReg;
  logic [W-1:0]  absA;
  logic [W-1:0]  absB;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [W-1:0]  specRes;
  logic [W-1:0]  result;
  logic          negRes;
  logic          special;
  logic          done;
  logic [CW-1:0] count;

  logic          isDiv;
  logic          signedA;
  logic          signedB;
  logic          negA;
  logic          negB;
  logic          bZero;
  logic          ovf;
  logic          isSpecial;
  logic [W-1:0]  magA;
  logic [W-1:0]  magB;
  logic [W-1:0]  specNext;
  logic [W:0]    mulSum;
  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic [2*W-1:0] prodSigned;
  logic [W-1:0]  quot;
  logic [W-1:0]  rem;
  logic [W-1:0]  finalRes;

  assign isDiv   = opReg[2];
  assign signedA = (opReg == 3'b001)
                 | (opReg == 3'b010)
                 | (opReg[2] & ~opReg[0]);
  assign signedB = (opReg == 3'b001)
                 | (opReg[2] & ~opReg[0]);
  assign negA    = signedA & aReg[W-1];
  assign negB    = signedB & bReg[W-1];
  assign magA    = negA ? -aReg : aReg;
  assign magB    = negB ? -bReg : bReg;
  assign bZero   = (bReg == '0);
  assign ovf     = opReg[2] & ~opReg[0]
                 & (aReg == {1'b1, {(W-1){1'b0}}})
                 & (&bReg);
  assign isSpecial = isDiv & (bZero | ovf);

  // Zero divisor wins over overflow; REM variants keep A.
  assign specNext = bZero
                  ? (opReg[1] ? aReg : '1)
                  : (opReg[1] ? '0 : aReg);

  assign mulSum  = {1'b0, hi}
                 + (lo[0] ? {1'b0, absA} : '0);
  assign shifted = {hi, lo[W-1]};
  assign diff    = shifted - {1'b0, absB};

  assign prodSigned = negRes ? -{hi, lo} : {hi, lo};
  assign quot = negRes ? -lo : lo;
  assign rem  = negRes ? -hi : hi;

  always_comb begin
    finalRes = '0;
    unique case (1'b1)
      special:
        finalRes = specRes;
      !special && !isDiv && opReg[1:0] == 2'b00:
        finalRes = prodSigned[W-1:0];
      !special && !isDiv && opReg[1:0] != 2'b00:
        finalRes = prodSigned[2*W-1:W];
      !special && isDiv && !opReg[1]:
        finalRes = quot;
      !special && isDiv && opReg[1]:
        finalRes = rem;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:
        if (bus.i_start) stateNext = PREP;
      PREP:
        stateNext = isSpecial ? FINISH : CALC;
      CALC:
        if (count == LAST) stateNext = FINISH;
      FINISH:
        stateNext = IDLE;
    endcase
    if (bus.i_flush) stateNext = IDLE;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      opReg   <= '0;
      aReg    <= '0;
      bReg    <= '0;
      absA    <= '0;
      absB    <= '0;
      hi      <= '0;
      lo      <= '0;
      specRes <= '0;
      result  <= '0;
      negRes  <= 1'b0;
      special <= 1'b0;
      done    <= 1'b0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_start && !bus.i_flush) begin
            opReg <= bus.i_op;
            aReg  <= bus.i_dataA;
            bReg  <= bus.i_dataB;
          end
        end
        PREP: begin
          absA    <= magA;
          absB    <= magB;
          negRes  <= (opReg == 3'b110)
                   ? negA : (negA ^ negB);
          special <= isSpecial;
          specRes <= specNext;
          hi      <= '0;
          lo      <= isDiv ? magA : magB;
          count   <= '0;
        end
        CALC: begin
          if (isDiv) begin
            if (!diff[W]) begin
              hi <= diff[W-1:0];
              lo <= {lo[W-2:0], 1'b1};
            end else begin
              hi <= shifted[W-1:0];
              lo <= {lo[W-2:0], 1'b0};
            end
          end else begin
            {hi, lo} <= {mulSum, lo[W-1:1]};
          end
          count <= (count == LAST) ? '0 : count + 1'b1;
        end
        FINISH: begin
          if (!bus.i_flush) begin
            result <= finalRes;
            done   <= 1'b1;
          end
        end
      endcase
      if (bus.i_flush) count <= '0;
    end
  end

  assign bus.o_ready  = (state == IDLE);
  assign bus.o_busy   = (state != IDLE);
  assign bus.o_done   = done;
  assign bus.o_result = result;
endmodule
